// File: rtl/vending_fsm.sv
// Two-beverage vending controller: coin credit, vend with change, cancel refund.
// Outputs are registered one-cycle pulses; credit is held in a 16-bit register.
module vending_fsm #(
  parameter int PRICE_1    = 50,
  parameter int PRICE_2    = 100,
  parameter int MAX_CREDIT = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] coin_in,
  input  logic [1:0]  button_in,
  output logic [1:0]  beverage_out,
  output logic [15:0] change_out
);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] credit_q, credit_d;
  logic [1:0]  bev_d;
  logic [15:0] chg_d;

  logic [15:0] base;
  logic [16:0] eff;
  logic        rej;
  logic [15:0] cred;
  logic [15:0] rej_v;
  logic [15:0] price;

  always_comb begin
    // Credit is only ever held in CREDIT; IDLE and VEND imply zero.
    base     = (state_q == CREDIT) ? credit_q : 16'd0;
    eff      = {1'b0, base} + {1'b0, coin_in};
    rej      = eff > 17'(MAX_CREDIT);
    cred     = rej ? base : eff[15:0];
    rej_v    = rej ? coin_in : 16'd0;
    price    = button_in[1] ? 16'(PRICE_2) : 16'(PRICE_1);
    bev_d    = 2'b00;
    chg_d    = rej_v;
    credit_d = cred;
    state_d  = (cred == 16'd0) ? IDLE : CREDIT;
    unique case (button_in)
      2'b01, 2'b10: begin
        if (cred >= price) begin
          bev_d    = button_in;
          chg_d    = cred - price + rej_v;
          credit_d = 16'd0;
          state_d  = VEND;
        end
      end
      2'b11: begin
        if (cred != 16'd0) begin
          chg_d    = cred + rej_v;
          credit_d = 16'd0;
          state_d  = VEND;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      credit_q     <= 16'd0;
      beverage_out <= 2'b00;
      change_out   <= 16'd0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      beverage_out <= bev_d;
      change_out   <= chg_d;
    end
  end

endmodule

// File: tb/tb_vending_fsm.sv
// Directed bench for vending_fsm: vend, change, cancel, reject, reset cases.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_vending_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] coin_in;
  logic [1:0]  button_in;
  logic [1:0]  beverage_out;
  logic [15:0] change_out;

  int checks = 0;
  int errors = 0;

  vending_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .coin_in     (coin_in),
    .button_in   (button_in),
    .beverage_out(beverage_out),
    .change_out  (change_out)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then return them to idle after the edge.
  task automatic drive(input logic [15:0] c, input logic [1:0] b);
    coin_in   = c;
    button_in = b;
    @(posedge clk);
    #1;
    coin_in   = 16'd0;
    button_in = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(16'd100, 2'b11);
    checks++;
    if (beverage_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_bev got %b want 00", beverage_out);
    end
    checks++;
    if (change_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_chg got %0d want 0", change_out);
    end
    rst = 1'b0;
    drive(16'd0, 2'b11);
    checks++;
    if (change_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_credit got %0d want 0", change_out);
    end
  endtask

  task automatic test_bev1_exact;
    drive(16'd25, 2'b00);
    drive(16'd25, 2'b00);
    drive(16'd0, 2'b01);
    checks++;
    if (beverage_out !== 2'b01 || change_out !== 16'd0) begin
      errors++;
      $display("FAIL bev1 got %b/%0d want 01/0", beverage_out, change_out);
    end
    drive(16'd0, 2'b00);
    checks++;
    if (beverage_out !== 2'b00 || change_out !== 16'd0) begin
      errors++;
      $display("FAIL bev1_pulse got %b/%0d want 00/0", beverage_out, change_out);
    end
  endtask

  task automatic test_bev2_change;
    drive(16'd100, 2'b00);
    drive(16'd50, 2'b00);
    drive(16'd0, 2'b10);
    checks++;
    if (beverage_out !== 2'b10 || change_out !== 16'd50) begin
      errors++;
      $display("FAIL bev2 got %b/%0d want 10/50", beverage_out, change_out);
    end
    drive(16'd0, 2'b11);
    checks++;
    if (change_out !== 16'd0) begin
      errors++;
      $display("FAIL bev2_credit got %0d want 0", change_out);
    end
  endtask

  task automatic test_insufficient;
    drive(16'd25, 2'b00);
    drive(16'd0, 2'b10);
    checks++;
    if (beverage_out !== 2'b00 || change_out !== 16'd0) begin
      errors++;
      $display("FAIL short got %b/%0d want 00/0", beverage_out, change_out);
    end
    drive(16'd0, 2'b11);
    checks++;
    if (beverage_out !== 2'b00 || change_out !== 16'd25) begin
      errors++;
      $display("FAIL cancel got %b/%0d want 00/25", beverage_out, change_out);
    end
  endtask

  task automatic test_reject;
    drive(16'd480, 2'b00);
    drive(16'd50, 2'b00);
    checks++;
    if (beverage_out !== 2'b00 || change_out !== 16'd50) begin
      errors++;
      $display("FAIL reject got %b/%0d want 00/50", beverage_out, change_out);
    end
    drive(16'd0, 2'b00);
    checks++;
    if (change_out !== 16'd0) begin
      errors++;
      $display("FAIL reject_pulse got %0d want 0", change_out);
    end
    drive(16'd0, 2'b11);
    checks++;
    if (change_out !== 16'd480) begin
      errors++;
      $display("FAIL reject_keep got %0d want 480", change_out);
    end
  endtask

  task automatic test_boundary;
    drive(16'd500, 2'b00);
    drive(16'd0, 2'b11);
    checks++;
    if (change_out !== 16'd500) begin
      errors++;
      $display("FAIL max_accept got %0d want 500", change_out);
    end
    drive(16'd501, 2'b00);
    checks++;
    if (change_out !== 16'd501) begin
      errors++;
      $display("FAIL over_max got %0d want 501", change_out);
    end
    drive(16'd0, 2'b11);
    checks++;
    if (change_out !== 16'd0) begin
      errors++;
      $display("FAIL over_max_credit got %0d want 0", change_out);
    end
  endtask

  task automatic test_same_cycle;
    drive(16'd50, 2'b01);
    checks++;
    if (beverage_out !== 2'b01 || change_out !== 16'd0) begin
      errors++;
      $display("FAIL same_cyc got %b/%0d want 01/0", beverage_out, change_out);
    end
    // Reject combined with vend: 380 change plus 100 rejected coin.
    drive(16'd480, 2'b00);
    drive(16'd100, 2'b10);
    checks++;
    if (beverage_out !== 2'b10 || change_out !== 16'd480) begin
      errors++;
      $display("FAIL rej_vend got %b/%0d want 10/480", beverage_out, change_out);
    end
  endtask

  task automatic test_back_to_back;
    drive(16'd100, 2'b01);
    checks++;
    if (beverage_out !== 2'b01 || change_out !== 16'd50) begin
      errors++;
      $display("FAIL b2b_vend got %b/%0d want 01/50", beverage_out, change_out);
    end
    drive(16'd25, 2'b00);
    checks++;
    if (beverage_out !== 2'b00 || change_out !== 16'd0) begin
      errors++;
      $display("FAIL b2b_vcyc got %b/%0d want 00/0", beverage_out, change_out);
    end
    drive(16'd30, 2'b01);
    checks++;
    if (beverage_out !== 2'b01 || change_out !== 16'd5) begin
      errors++;
      $display("FAIL b2b_second got %b/%0d want 01/5", beverage_out, change_out);
    end
  endtask

  task automatic test_rst_mid;
    drive(16'd100, 2'b00);
    rst = 1'b1;
    drive(16'd0, 2'b00);
    rst = 1'b0;
    drive(16'd0, 2'b01);
    checks++;
    if (beverage_out !== 2'b00 || change_out !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid got %b/%0d want 00/0", beverage_out, change_out);
    end
    drive(16'd0, 2'b11);
    checks++;
    if (change_out !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_cancel got %0d want 0", change_out);
    end
  endtask

  initial begin
    rst       = 1'b1;
    coin_in   = 16'd0;
    button_in = 2'b00;
    test_reset();
    test_bev1_exact();
    test_bev2_change();
    test_insufficient();
    test_reject();
    test_boundary();
    test_same_cycle();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
